// File: rtl/rca_limb_sequencer.sv
// Multi-cycle wide adder: streams N-bit limb pairs through one N-bit ripple-carry stage.
// Optional signed-overflow output out_ovf is enabled by defining RCA_LIMB_OVF_EN.

module limb_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[N];
endmodule

module rca_limb_sequencer #(
    parameter int N     = 4,
    parameter int LIMBS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*LIMBS-1:0] in_a,
    input  logic [N*LIMBS-1:0] in_b,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*LIMBS-1:0] out_sum,
    output logic               out_cout,
`ifdef RCA_LIMB_OVF_EN
    output logic               out_ovf,
`endif
    output logic               busy
);
    localparam int W    = N * LIMBS;
    localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [W-1:0]      a_sh_reg, b_sh_reg, sum_sh_reg, out_sum_reg;
    logic              carry_reg, out_cout_reg, out_valid_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [N-1:0]      limb_sum;
    logic              limb_cout;
    logic [W-1:0]      sum_shifted;
    logic              last_limb;
`ifdef RCA_LIMB_OVF_EN
    logic              out_ovf_reg;
`endif

    limb_rca #(.N(N)) u_rca (
        .a    (a_sh_reg[N-1:0]),
        .b    (b_sh_reg[N-1:0]),
        .cin  (carry_reg),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    // Each new limb enters at the top, so after LIMBS shifts limb 0 sits at bit 0.
    generate
        if (LIMBS == 1) begin : g_single
            assign sum_shifted = limb_sum;
        end else begin : g_multi
            assign sum_shifted = {limb_sum, sum_sh_reg[W-1:N]};
        end
    endgenerate

    assign last_limb = (idx_reg == IDXW'(LIMBS - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_limb) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_sh_reg    <= '0;
            out_sum_reg   <= '0;
            carry_reg     <= 1'b0;
            out_cout_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            idx_reg       <= '0;
`ifdef RCA_LIMB_OVF_EN
            out_ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= in_a;
                        b_sh_reg  <= in_b;
                        carry_reg <= in_cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_sh_reg <= sum_shifted;
                    carry_reg  <= limb_cout;
                    a_sh_reg   <= a_sh_reg >> N;
                    b_sh_reg   <= b_sh_reg >> N;
                    idx_reg    <= idx_reg + IDXW'(1);
                    if (last_limb) begin
                        out_sum_reg   <= sum_shifted;
                        out_cout_reg  <= limb_cout;
                        out_valid_reg <= 1'b1;
`ifdef RCA_LIMB_OVF_EN
                        // The low limb of the shifters now holds the operands' top limb.
                        out_ovf_reg   <= (a_sh_reg[N-1] == b_sh_reg[N-1]) &&
                                         (limb_sum[N-1] != a_sh_reg[N-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_cout  = out_cout_reg;
`ifdef RCA_LIMB_OVF_EN
    assign out_ovf   = out_ovf_reg;
`endif
endmodule

// File: tb/tb_rca_limb_sequencer.sv
// Directed bench for rca_limb_sequencer (N=4, LIMBS=4); checks out_ovf when RCA_LIMB_OVF_EN is set.
`timescale 1ns/1ps

module tb_rca_limb_sequencer;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;
`ifdef RCA_LIMB_OVF_EN
    logic        out_ovf;
`endif

    int total = 0;
    int bad   = 0;

    rca_limb_sequencer #(.N(4), .LIMBS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef RCA_LIMB_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present an operand set at a falling edge and let the next rising edge accept it.
    task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input bit keep_valid);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Called just after the accept edge; expects out_valid after exactly 4 edges.
    task automatic wait_result(input string tag, input logic [15:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
        int lat;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, ".latency"}, lat, 4);
        check({tag, ".sum"}, out_sum, exp_sum);
        check({tag, ".cout"}, out_cout, exp_cout);
`ifdef RCA_LIMB_OVF_EN
        check({tag, ".ovf"}, out_ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("note %s: unexpected x ovf", tag);
`endif
        check({tag, ".busy"}, busy, 1'b1);
        check({tag, ".in_ready_done"}, in_ready, 1'b0);
        $display("op %s: sum=%04h cout=%0b lat=%0d", tag, out_sum, out_cout, lat);
    endtask

    // With out_ready high the DONE handshake completes on the next edge.
    task automatic handshake(input string tag, input logic [15:0] exp_sum);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".valid_cleared"}, out_valid, 1'b0);
        check({tag, ".in_ready_back"}, in_ready, 1'b1);
        check({tag, ".busy_cleared"}, busy, 1'b0);
        check({tag, ".sum_kept"}, out_sum, exp_sum);
    endtask

    initial begin
        bit seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.out_sum", out_sum, 16'h0000);
        check("reset.out_cout", out_cout, 1'b0);
        check("reset.in_ready", in_ready, 1'b1);
        check("reset.busy", busy, 1'b0);
`ifdef RCA_LIMB_OVF_EN
        check("reset.out_ovf", out_ovf, 1'b0);
`endif

        start_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result("basic", 16'h5555, 1'b0, 1'b0);
        handshake("basic", 16'h5555);

        start_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_result("ripple", 16'h0000, 1'b1, 1'b0);
        handshake("ripple", 16'h0000);

        start_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_result("ovf_pos", 16'h8000, 1'b0, 1'b1);
        handshake("ovf_pos", 16'h8000);

        start_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_result("ovf_neg", 16'h0000, 1'b1, 1'b1);
        handshake("ovf_neg", 16'h0000);

        // Backpressure: a second operand set stays offered the whole time.
        out_ready = 1'b0;
        start_op("bp", 16'h00F0, 16'h0F10, 1'b0, 1'b1);
        in_a = 16'hAAAA;
        wait_result("bp", 16'h1000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp.hold_sum", out_sum, 16'h1000);
            check("bp.hold_valid", out_valid, 1'b1);
            check("bp.hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp.valid_cleared", out_valid, 1'b0);
        check("bp.in_ready_back", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result("bp_next", 16'hB9BA, 1'b0, 1'b0);
        handshake("bp_next", 16'hB9BA);

        // Reset during the second RUN cycle discards the pending result.
        start_op("midrst", 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst.out_valid", out_valid, 1'b0);
        check("midrst.in_ready", in_ready, 1'b1);
        check("midrst.busy", busy, 1'b0);
        check("midrst.out_sum", out_sum, 16'h0000);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst.never_valid", seen_valid, 1'b0);

        start_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_result("after_rst", 16'h0002, 1'b0, 1'b0);
        handshake("after_rst", 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
